// File: rtl/hamming_secded_encoder.sv
// Multi-cycle Hamming SEC / SEC-DED encoder with valid/ready handshakes on both sides.
// Parity bits are registered one per cycle, followed by an optional overall-parity cycle.
module hamming_secded_encoder #(
    parameter int DATA_W     = 4,
    parameter int EXT_PARITY = 1,
    localparam int PAR_W  = (DATA_W <= 1)  ? 2 :
                            (DATA_W <= 4)  ? 3 :
                            (DATA_W <= 11) ? 4 :
                            (DATA_W <= 26) ? 5 : 6,
    localparam int CODE_W = DATA_W + PAR_W + EXT_PARITY
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] data_in,
    input  logic              mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] data_out,
    output logic              busy
);

    localparam int HW_W = DATA_W + PAR_W;
    localparam int K_W  = $clog2(PAR_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        PAR,
        XPAR,
        DONE
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [DATA_W-1:0]   cap_data;
    logic                cap_mode;
    logic [K_W-1:0]      k;
    logic [PAR_W-1:0]    par;
    logic [PAR_W-1:0]    par_calc;
    logic [HW_W-1:0]     dpos;
    logic [HW_W-1:0]     hw;
    logic                overall;
    logic [CODE_W-1:0]   code;
    logic                load_out;

    // Data bit at position j has index j-1 minus the count of powers of two <= j.
    always_comb begin
        dpos = '0;
        for (int unsigned j = 1; j <= HW_W; j++) begin
            if ((j & (j - 1)) != 0) begin
                dpos[j-1] = cap_data[j - 1 - $clog2(j + 1)];
            end
        end
    end

    always_comb begin
        par_calc = '0;
        for (int unsigned kk = 0; kk < PAR_W; kk++) begin
            par_calc[kk] = ~cap_mode;
            for (int unsigned j = 1; j <= HW_W; j++) begin
                if (j[kk]) begin
                    par_calc[kk] = par_calc[kk] ^ dpos[j-1];
                end
            end
        end
    end

    always_comb begin
        hw = dpos;
        for (int unsigned kk = 0; kk < PAR_W; kk++) begin
            hw[(1 << kk) - 1] = par[kk];
        end
        overall = (^hw) ^ ~cap_mode;
        code = '0;
        code[HW_W-1:0] = hw;
        if (EXT_PARITY != 0) begin
            code[CODE_W-1] = overall;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (in_valid) state_next = PAR;
            PAR: begin
                // k reaching PAR_W means every parity bit has been registered.
                if (k == K_W'(PAR_W)) begin
                    state_next = (EXT_PARITY != 0) ? XPAR : DONE;
                end
            end
            XPAR: state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    assign load_out = (state != DONE) && (state_next == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cap_data  <= '0;
            cap_mode  <= 1'b0;
            k         <= '0;
            par       <= '0;
            data_out  <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        cap_data <= data_in;
                        cap_mode <= mode;
                        k        <= '0;
                        par      <= '0;
                    end
                end
                PAR: begin
                    if (k != K_W'(PAR_W)) begin
                        for (int unsigned kk = 0; kk < PAR_W; kk++) begin
                            if (k == K_W'(kk)) par[kk] <= par_calc[kk];
                        end
                        k <= k + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
            if (load_out) begin
                data_out  <= code;
                out_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hamming_secded_encoder.sv
// Scoreboard bench for hamming_secded_encoder: default SEC-DED, plain SEC, and 11-bit instances.
module tb_hamming_secded_encoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic       a_in_valid, a_in_ready, a_mode, a_out_valid, a_out_ready, a_busy;
    logic [3:0] a_data_in;
    logic [7:0] a_data_out;

    logic       b_in_valid, b_in_ready, b_mode, b_out_valid, b_out_ready, b_busy;
    logic [3:0] b_data_in;
    logic [6:0] b_data_out;

    logic        c_in_valid, c_in_ready, c_mode, c_out_valid, c_out_ready, c_busy;
    logic [10:0] c_data_in;
    logic [15:0] c_data_out;

    int total = 0;
    int bad   = 0;

    logic [7:0]  qa[$];
    logic [6:0]  qb[$];
    logic [15:0] qc[$];

    hamming_secded_encoder #(.DATA_W(4), .EXT_PARITY(1)) dut_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .data_in(a_data_in), .mode(a_mode), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .data_out(a_data_out), .busy(a_busy)
    );

    hamming_secded_encoder #(.DATA_W(4), .EXT_PARITY(0)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .data_in(b_data_in), .mode(b_mode), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .data_out(b_data_out), .busy(b_busy)
    );

    hamming_secded_encoder #(.DATA_W(11), .EXT_PARITY(1)) dut_c (
        .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .data_in(c_data_in), .mode(c_mode), .out_valid(c_out_valid),
        .out_ready(c_out_ready), .data_out(c_data_out), .busy(c_busy)
    );

    // Parity bits obtained as the XOR of the positions of set data bits.
    function automatic logic [15:0] ref_enc11(input logic [10:0] d, input logic m);
        logic [15:0] c;
        logic [3:0]  s;
        int          di;
        c = '0; s = '0; di = 0;
        for (int j = 1; j <= 15; j++) begin
            if ((j & (j - 1)) != 0) begin
                c[j-1] = d[di];
                if (d[di]) s = s ^ 4'(j);
                di++;
            end
        end
        if (!m) s = ~s;
        for (int k = 0; k < 4; k++) c[(1 << k) - 1] = s[k];
        c[15] = (^c[14:0]) ^ ~m;
        return c;
    endfunction

    function automatic logic [3:0] syn15(input logic [15:0] c);
        logic [3:0] s;
        s = '0;
        for (int j = 1; j <= 15; j++) if (c[j-1]) s = s ^ 4'(j);
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_send(input logic [3:0] d, input logic m, input logic [7:0] exp);
        int n;
        n = 0;
        while (a_in_ready !== 1'b1 && n < 20) begin tick(); n++; end
        total++;
        if (a_in_ready !== 1'b1) begin
            bad++; $display("FAIL a_ready_wait: in_ready=%b required 1", a_in_ready);
        end
        a_in_valid = 1'b1; a_data_in = d; a_mode = m;
        tick();
        a_in_valid = 1'b0;
        qa.push_back(exp);
    endtask

    task automatic a_wait_out(input bit toggle, output int n);
        n = 0;
        while (a_out_valid !== 1'b1 && n < 20) begin
            if (toggle) begin
                a_data_in = ~a_data_in; a_mode = ~a_mode;
                a_in_valid = ~a_in_valid; a_out_ready = ~a_out_ready;
            end
            tick();
            n++;
        end
        a_in_valid = 1'b0;
        a_out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_in_valid = 0; a_out_ready = 0; a_data_in = '0; a_mode = 0;
        b_in_valid = 0; b_out_ready = 0; b_data_in = '0; b_mode = 0;
        c_in_valid = 0; c_out_ready = 0; c_data_in = '0; c_mode = 0;
        tick(); tick();
        total++;
        if (a_data_out !== 8'h00 || a_out_valid !== 1'b0) begin
            bad++; $display("FAIL reset_a_out: data_out=%h out_valid=%b required 00/0", a_data_out, a_out_valid);
        end
        total++;
        if (a_in_ready !== 1'b1 || a_busy !== 1'b0) begin
            bad++; $display("FAIL reset_a_hs: in_ready=%b busy=%b required 1/0", a_in_ready, a_busy);
        end
        total++;
        if (b_data_out !== 7'h00 || b_out_valid !== 1'b0 || b_in_ready !== 1'b1 || b_busy !== 1'b0) begin
            bad++; $display("FAIL reset_b: data_out=%h ov=%b ir=%b busy=%b required 00/0/1/0",
                            b_data_out, b_out_valid, b_in_ready, b_busy);
        end
        total++;
        if (c_data_out !== 16'h0000 || c_out_valid !== 1'b0 || c_in_ready !== 1'b1 || c_busy !== 1'b0) begin
            bad++; $display("FAIL reset_c: data_out=%h ov=%b ir=%b busy=%b required 0000/0/1/0",
                            c_data_out, c_out_valid, c_in_ready, c_busy);
        end
        rst = 1'b0;
    endtask

    task automatic test_vectors();
        logic [3:0] vd[4] = '{4'b1011, 4'b1011, 4'h0, 4'hF};
        logic       vm[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [7:0] ve[4] = '{8'h55, 8'h5E, 8'h0B, 8'hFF};
        logic [7:0] exp;
        int n;
        for (int i = 0; i < 4; i++) begin
            a_send(vd[i], vm[i], ve[i]);
            a_wait_out(1'b0, n);
            total++;
            if (n != 5) begin bad++; $display("FAIL vec_latency[%0d]: edges=%0d required 5", i, n); end
            exp = (qa.size() > 0) ? qa.pop_front() : 8'hxx;
            total++;
            if (a_data_out !== exp) begin
                bad++; $display("FAIL vec_data[%0d]: data_out=%h required %h", i, a_data_out, exp);
            end
            total++;
            if (a_busy !== 1'b1 || a_in_ready !== 1'b0) begin
                bad++; $display("FAIL vec_done_flags[%0d]: busy=%b in_ready=%b required 1/0", i, a_busy, a_in_ready);
            end
            a_out_ready = 1'b1;
            tick();
            a_out_ready = 1'b0;
            total++;
            if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_data_out !== exp) begin
                bad++; $display("FAIL vec_release[%0d]: ov=%b ir=%b data_out=%h required 0/1/%h",
                                i, a_out_valid, a_in_ready, a_data_out, exp);
            end
        end
    endtask

    task automatic test_capture_hold();
        int n;
        logic [7:0] exp;
        a_send(4'b1011, 1'b1, 8'h55);
        a_wait_out(1'b1, n);
        total++;
        if (n != 5) begin bad++; $display("FAIL hold_latency: edges=%0d required 5", n); end
        exp = (qa.size() > 0) ? qa.pop_front() : 8'hxx;
        total++;
        if (a_data_out !== exp) begin bad++; $display("FAIL hold_capture: data_out=%h required %h", a_data_out, exp); end
        for (int i = 0; i < 10; i++) begin
            a_data_in = ~a_data_in; a_mode = ~a_mode; a_in_valid = ~a_in_valid;
            tick();
            total++;
            if (a_out_valid !== 1'b1 || a_data_out !== exp || a_in_ready !== 1'b0) begin
                bad++; $display("FAIL hold_stable[%0d]: ov=%b data_out=%h ir=%b required 1/%h/0",
                                i, a_out_valid, a_data_out, a_in_ready, exp);
            end
        end
        a_in_valid = 1'b0;
        a_out_ready = 1'b1;
        tick();
        a_out_ready = 1'b0;
        total++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
            bad++; $display("FAIL hold_release: ov=%b ir=%b required 0/1", a_out_valid, a_in_ready);
        end
    endtask

    task automatic test_reset_priority();
        int n;
        int seen;
        logic [7:0] exp;
        a_send(4'b1011, 1'b1, 8'h55);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        qa.delete();
        total++;
        if (a_data_out !== 8'h00 || a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_busy !== 1'b0) begin
            bad++; $display("FAIL rst_mid_par: data_out=%h ov=%b ir=%b busy=%b required 00/0/1/0",
                            a_data_out, a_out_valid, a_in_ready, a_busy);
        end
        seen = 0;
        for (int i = 0; i < 8; i++) begin tick(); if (a_out_valid === 1'b1) seen++; end
        total++;
        if (seen != 0) begin bad++; $display("FAIL rst_no_pulse: out_valid cycles=%0d required 0", seen); end
        a_send(4'b1011, 1'b1, 8'h55);
        a_wait_out(1'b0, n);
        exp = (qa.size() > 0) ? qa.pop_front() : 8'hxx;
        total++;
        if (n != 5 || a_data_out !== exp) begin
            bad++; $display("FAIL rst_after_word: edges=%0d data_out=%h required 5/%h", n, a_data_out, exp);
        end
        rst = 1'b1;
        a_out_ready = 1'b1;
        tick();
        rst = 1'b0;
        a_out_ready = 1'b0;
        total++;
        if (a_data_out !== 8'h00 || a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
            bad++; $display("FAIL rst_in_done: data_out=%h ov=%b ir=%b required 00/0/1",
                            a_data_out, a_out_valid, a_in_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] wd[3] = '{4'h0, 4'hF, 4'b1011};
        logic       wm[3] = '{1'b0, 1'b1, 1'b0};
        logic [7:0] we[3] = '{8'h0B, 8'hFF, 8'h5E};
        int  acc_edges[$];
        int  widx;
        int  n;
        bit  acc;
        logic [7:0] exp;
        widx = 0;
        a_out_ready = 1'b1;
        a_in_valid = 1'b1; a_data_in = wd[0]; a_mode = wm[0];
        for (int cyc = 1; cyc <= 15; cyc++) begin
            acc = (a_in_valid === 1'b1) && (a_in_ready === 1'b1);
            tick();
            if (acc) begin
                acc_edges.push_back(cyc);
                qa.push_back(we[widx]);
                widx = (widx + 1) % 3;
                a_data_in = wd[widx]; a_mode = wm[widx];
            end
            if (a_out_valid === 1'b1) begin
                exp = (qa.size() > 0) ? qa.pop_front() : 8'hxx;
                total++;
                if (a_data_out !== exp) begin
                    bad++; $display("FAIL b2b_data@%0d: data_out=%h required %h", cyc, a_data_out, exp);
                end
            end
        end
        a_in_valid = 1'b0;
        n = 0;
        while (a_out_valid !== 1'b1 && n < 20) begin tick(); n++; end
        exp = (qa.size() > 0) ? qa.pop_front() : 8'hxx;
        total++;
        if (a_out_valid !== 1'b1 || a_data_out !== exp) begin
            bad++; $display("FAIL b2b_drain: ov=%b data_out=%h required 1/%h", a_out_valid, a_data_out, exp);
        end
        tick();
        a_out_ready = 1'b0;
        total++;
        if (acc_edges.size() != 3) begin
            bad++; $display("FAIL b2b_count: accepts=%0d required 3", acc_edges.size());
        end else if (acc_edges[1] - acc_edges[0] != 7 || acc_edges[2] - acc_edges[1] != 7) begin
            bad++; $display("FAIL b2b_spacing: gaps=%0d,%0d required 7,7",
                            acc_edges[1] - acc_edges[0], acc_edges[2] - acc_edges[1]);
        end
    endtask

    task automatic test_no_ext();
        logic [6:0] exp;
        int n;
        for (int i = 0; i < 2; i++) begin
            b_in_valid = 1'b1; b_data_in = 4'b1011; b_mode = (i == 0);
            tick();
            b_in_valid = 1'b0;
            qb.push_back((i == 0) ? 7'h55 : 7'h5E);
            n = 0;
            while (b_out_valid !== 1'b1 && n < 20) begin tick(); n++; end
            exp = (qb.size() > 0) ? qb.pop_front() : 7'hxx;
            total++;
            if (n != 4) begin bad++; $display("FAIL sec_latency[%0d]: edges=%0d required 4", i, n); end
            total++;
            if (b_data_out !== exp) begin bad++; $display("FAIL sec_data[%0d]: data_out=%h required %h", i, b_data_out, exp); end
            b_out_ready = 1'b1;
            tick();
            b_out_ready = 1'b0;
        end
    endtask

    task automatic test_wide();
        logic [10:0] d;
        logic        m;
        logic [15:0] exp;
        logic [3:0]  base;
        bit          flips_ok;
        int          n;
        for (int i = 0; i < 12; i++) begin
            d = 11'($urandom_range(0, 2047));
            m = i[0];
            c_in_valid = 1'b1; c_data_in = d; c_mode = m;
            tick();
            c_in_valid = 1'b0;
            qc.push_back(ref_enc11(d, m));
            n = 0;
            while (c_out_valid !== 1'b1 && n < 20) begin tick(); n++; end
            exp = (qc.size() > 0) ? qc.pop_front() : 16'hxxxx;
            total++;
            if (n != 6) begin bad++; $display("FAIL wide_latency[%0d]: edges=%0d required 6", i, n); end
            total++;
            if (c_data_out !== exp) begin bad++; $display("FAIL wide_data[%0d]: data_out=%h required %h", i, c_data_out, exp); end
            total++;
            if ((^c_data_out) !== ~m) begin
                bad++; $display("FAIL wide_overall[%0d]: xor=%b required %b", i, ^c_data_out, ~m);
            end
            base = syn15(c_data_out);
            flips_ok = (base == (m ? 4'h0 : 4'hF));
            for (int j = 1; j <= 15; j++) begin
                if ((syn15(c_data_out ^ (16'd1 << (j - 1))) ^ base) != 4'(j)) flips_ok = 1'b0;
            end
            total++;
            if (!flips_ok) begin bad++; $display("FAIL wide_syndrome[%0d]: base=%h flip check=0 required 1", i, base); end
            c_out_ready = 1'b1;
            tick();
            c_out_ready = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_capture_hold();
        test_reset_priority();
        test_back_to_back();
        test_no_ext();
        test_wide();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hamming_secded_encoder.md
HAMMING_SECDED_ENCODER -- requirements
Module: hamming_secded_encoder

Interface
REQ-001 SHALL have parameter DATA_W, default 4, data word width, legal range 4..26.
REQ-002 SHALL have parameter EXT_PARITY, default 1, where 1 appends an overall parity bit (SEC-DED) and 0 gives plain Hamming SEC.
REQ-003 SHALL derive localparam PAR_W as the smallest R with 2^R >= DATA_W+R+1 (DATA_W=4 gives 3; DATA_W=11 gives 4).
REQ-004 SHALL derive localparam CODE_W = DATA_W + PAR_W + EXT_PARITY.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset, synchronous and active-high.
REQ-007 in_valid  input  1  data_in/mode offered.
REQ-008 in_ready  output  1  block can accept a word.
REQ-009 data_in  input  DATA_W  data word to encode.
REQ-010 mode  input  1  parity sense, 1 = even and 0 = odd.
REQ-011 out_valid  output  1  data_out holds a finished codeword.
REQ-012 out_ready  input  1  consumer accepts data_out.
REQ-013 data_out  output  CODE_W  encoded codeword.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, PAR, XPAR, DONE, and register the state.
REQ-016 in_ready SHALL be high only in IDLE; an accept occurs on an edge where in_valid and in_ready are both high.
REQ-017 On accept: capture data_in and mode into internal registers, clear the parity index k to 0, go to PAR; later changes on data_in and mode SHALL have no effect on the word in flight.
REQ-018 PAR: each cycle computes exactly one Hamming parity bit p[k] from the captured word and increments k; after k = PAR_W-1 the FSM goes to XPAR if EXT_PARITY=1, else to DONE.
REQ-019 Codeword layout, 1-based position j, data_out[j-1]: parity bit p[k] sits at j = 2^k; data bits fill the remaining positions j = 1..DATA_W+PAR_W in ascending order, LSB first.
REQ-020 p[k] (even) SHALL be the XOR of all data-bearing positions j with bit k of j set; in odd mode p[k] is inverted.
REQ-021 XPAR (one cycle): overall bit at data_out[CODE_W-1] SHALL make the XOR of all CODE_W bits 0 in even mode and 1 in odd mode.
REQ-022 DONE entry edge: data_out is loaded with the assembled codeword and out_valid is set; the entry edge is PAR_W+EXT_PARITY+1 edges after the accept edge (5 for the defaults).
REQ-023 In DONE, data_out and out_valid SHALL hold stable until out_ready is high.
REQ-024 On the edge where out_valid and out_ready are both high: clear out_valid and go to IDLE; data_out keeps its last value.
REQ-025 out_ready while out_valid is low, and in_valid while in_ready is low, SHALL be ignored.
REQ-026 The minimum accept-to-accept spacing SHALL be PAR_W+EXT_PARITY+3 cycles when out_ready is held high.

Reset
REQ-027 When rst is high at an edge: state becomes IDLE, k, parity and capture registers clear, data_out = 0, out_valid = 0; in_ready = 1 and busy = 0 after that edge.
REQ-028 rst SHALL take priority over every handshake, including mid-PAR, mid-XPAR and DONE; the word in flight is discarded with no out_valid pulse.

Verification
REQ-029 Defaults, mode=1, data_in=4'b1011 accepted -> out_valid rises exactly 5 edges later with data_out=8'h55.
REQ-030 Defaults, mode=0, data_in=4'b1011 -> data_out=8'h5E; mode=0, data_in=4'h0 -> 8'h0B; mode=1, data_in=4'hF -> 8'hFF.
REQ-031 Defaults, data_in and mode toggled every cycle after accept -> data_out still reflects the captured word; out_ready held low 10 cycles -> data_out and out_valid stable throughout, in_ready=0.
REQ-032 rst asserted for 1 cycle during PAR (k=1) -> next edge data_out=0, out_valid=0, in_ready=1; a following accept of 4'b1011 with mode=1 yields 8'h55 on schedule.
REQ-033 EXT_PARITY=0, DATA_W=4, mode=1, data_in=4'b1011 -> data_out=7'h55 after 4 edges.
REQ-034 DATA_W=11, EXT_PARITY=1, random words in both modes -> out_valid after 6 edges; the XOR of data_out matches the mode; single-bit flips give a syndrome equal to the flipped position in a reference model.
